// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES receive path: block geometry,
// the assembly-buffer state encoding and a slot-to-bit-position helper.
package aes_uart_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = 8 * AES_BLOCK_BYTES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_e;

  // Byte 0 of a block lives in the most significant byte, so slot k of an
  // nbytes-wide block starts at bit 8*(nbytes-1-k).
  function automatic int slot_lsb(input int slot, input int nbytes);
    return 8 * (nbytes - 1 - slot);
  endfunction

endpackage

// File: rtl/rx_strobe_edge.sv
// Registered rising-edge detector for the UART_Rx done/err strobes.
// A level held high for many cycles yields a single one-cycle event,
// delivered one cycle after the input rises.
module rx_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic strobe_q;

  // Remember last cycle's level and emit a pulse on a 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      strobe_q <= strobe;
      pulse    <= strobe & ~strobe_q;
    end
  end

endmodule

// File: rtl/uart_rx_block_ctrl.sv
// UART receive sequencer: enables UART_Rx, packs its byte stream MSB-first
// into BLOCK_BYTES-wide blocks and hands each finished block to the AES
// input stage over a valid/ready handshake. Partial blocks are dropped on a
// framing error; bytes arriving while a full block is stuck are dropped and
// flagged as overrun.
// Optional build macro: RX_TIMEOUT_EN -- also drops a partial block after
// TIMEOUT_CYCLES idle cycles without a new byte.
module uart_rx_block_ctrl
  import aes_uart_pkg::*;
#(
  parameter int BLOCK_BYTES    = AES_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rx_en,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     rx_err,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [CNT_W-1:0]         byte_cnt,
  output logic                     frame_drop,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int               BLK_W     = 8 * BLOCK_BYTES;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  // The counter must be able to hold the "buffer full" value.
  if ((1 << CNT_W) <= BLOCK_BYTES) begin : g_cnt_w_check
    $error("CNT_W too narrow for BLOCK_BYTES");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  rx_state_e        state;
  logic [BLK_W-1:0] asm_buf;
  logic             done_evt;
  logic             err_evt;
  logic             byte_evt;
  logic             timeout_hit;
  logic             xfer;

  rx_strobe_edge u_done_edge (
    .clk    (clk),
    .rst    (rst),
    .strobe (rx_done),
    .pulse  (done_evt)
  );

  rx_strobe_edge u_err_edge (
    .clk    (clk),
    .rst    (rst),
    .strobe (rx_err),
    .pulse  (err_evt)
  );

  // A byte only counts when no error arrives with it.
  assign byte_evt = done_evt & ~err_evt;

  // A full buffer moves out when the output register is empty or is being
  // emptied by the AES core in this same cycle.
  assign xfer = (state == HOLD) && (!blk_valid || blk_ready);

`ifdef RX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;

  // Count idle cycles since the last byte while a partial block is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != COLLECT || byte_evt) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_LAST) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == COLLECT) && !byte_evt && (idle_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Assembly-buffer FSM together with the registered outputs it drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_en      <= 1'b0;
      asm_buf    <= '0;
      blk_data   <= '0;
      blk_valid  <= 1'b0;
      byte_cnt   <= '0;
      frame_drop <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_en      <= 1'b1;
      frame_drop <= 1'b0;

      if (blk_valid && blk_ready) begin
        blk_valid <= 1'b0;
      end
      if (ovr_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (byte_evt) begin
            asm_buf[slot_lsb(0, BLOCK_BYTES) +: 8] <= rx_data;
            byte_cnt <= ONE_CNT;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (err_evt || timeout_hit) begin
            byte_cnt   <= '0;
            frame_drop <= 1'b1;
            state      <= IDLE;
          end else if (byte_evt) begin
            asm_buf[slot_lsb(int'(byte_cnt), BLOCK_BYTES) +: 8] <= rx_data;
            if (byte_cnt == LAST_SLOT) begin
              byte_cnt <= FULL_CNT;
              state    <= HOLD;
            end else begin
              byte_cnt <= byte_cnt + ONE_CNT;
            end
          end
        end

        HOLD: begin
          if (xfer) begin
            blk_data  <= asm_buf;
            blk_valid <= 1'b1;
            if (byte_evt) begin
              asm_buf[slot_lsb(0, BLOCK_BYTES) +: 8] <= rx_data;
              byte_cnt <= ONE_CNT;
              state    <= COLLECT;
            end else begin
              byte_cnt <= '0;
              state    <= IDLE;
            end
          end else if (byte_evt) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          byte_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
